muldiv_sequencer: RTL and testbench

Iterative multiply/divide controller that sits beside the execute stage and owns the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from EX and sequences a shift-add multiplier or restoring divider over W cycles. It also drives a pipeline stall while a result is pending, so the single-cycle ALU path is never blocked by long-latency ops except on a real HI/LO dependency.

---
 rtl/muldiv_sequencer.sv | 144 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer owning the HI/LO registers.
// Shift-add multiply or restoring divide, one step per cycle over W cycles, then a sign-fixup cycle.
module muldiv_sequencer #(
  parameter int           W      = 32,
  parameter logic [W-1:0] HI_RST = '0,
  parameter logic [W-1:0] LO_RST = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_in,
  input  logic [2:0]   op_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         read_req_in,
  output logic         stall_out,
  output logic         busy_out,
  output logic         done_out,
  output logic [W-1:0] hi_out,
  output logic [W-1:0] lo_out
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           op_div;
  logic           neg_main;
  logic           neg_rem;
  logic           b_zero;
  logic [W-1:0]   a_orig;
  logic [W-1:0]   dvs;
  logic [W-1:0]   acc_hi;
  logic [W-1:0]   acc_lo;

  logic signed [W-1:0] a_s;
  logic signed [W-1:0] b_s;
  logic                sgn_op;
  logic                a_neg;
  logic                b_neg;
  logic [W:0]          mul_sum;
  logic [W:0]          div_shift;
  logic [W-1:0]        div_rem;
  logic                div_ge;
  logic [2*W-1:0]      prod_fix;
  logic [W-1:0]        fix_hi;
  logic [W-1:0]        fix_lo;

  function automatic logic [W-1:0] neg_if(input logic [W-1:0] x, input logic neg);
    neg_if = neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*W-1:0] neg_if_wide(input logic [2*W-1:0] x, input logic neg);
    neg_if_wide = neg ? (~x + 1'b1) : x;
  endfunction

  assign a_s    = a_in;
  assign b_s    = b_in;
  assign sgn_op = ~op_in[0];
  assign a_neg  = sgn_op & (a_s < 0);
  assign b_neg  = sgn_op & (b_s < 0);

  assign busy_out  = (state != IDLE);
  assign stall_out = busy_out & (start_in | read_req_in);

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : {(W+1){1'b0}});
    div_shift = {acc_hi, acc_lo[W-1]};
    div_ge    = (div_shift >= {1'b0, dvs});
    // Partial remainder is always below the divisor, so W bits hold the difference.
    div_rem   = div_shift[W-1:0] - dvs;
  end

  always_comb begin
    prod_fix = neg_if_wide({acc_hi, acc_lo}, neg_main);
    fix_hi   = prod_fix[2*W-1:W];
    fix_lo   = prod_fix[W-1:0];
    if (op_div) begin
      if (b_zero) begin
        fix_hi = a_orig;
        fix_lo = '1;
      end else begin
        fix_hi = neg_if(acc_hi, neg_rem);
        fix_lo = neg_if(acc_lo, neg_main);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_out   <= HI_RST;
      lo_out   <= LO_RST;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            case (op_in)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                state    <= RUN;
                cnt      <= CW'(W - 1);
                op_div   <= op_in[1];
                neg_main <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                b_zero   <= (b_in == '0);
                a_orig   <= a_in;
                acc_hi   <= '0;
                // Multiply: acc_lo holds the multiplier; divide: acc_lo holds the dividend.
                acc_lo   <= op_in[1] ? neg_if(a_in, a_neg) : neg_if(b_in, b_neg);
                dvs      <= op_in[1] ? neg_if(b_in, b_neg) : neg_if(a_in, a_neg);
              end
              3'b100:  hi_out <= a_in;
              3'b101:  lo_out <= a_in;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (!op_div) begin
            acc_hi <= mul_sum[W:1];
            acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
          end else begin
            acc_hi <= div_ge ? div_rem : div_shift[W-1:0];
            acc_lo <= {acc_lo[W-2:0], div_ge};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIXUP;
        end
        FIXUP: begin
          hi_out   <= fix_hi;
          lo_out   <= fix_lo;
          done_out <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table of mul/div ops plus
// hand-written MTHI/MTLO, stall, and mid-operation reset sequences.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start_in;
  logic [2:0]  op_in;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        read_req_in;
  logic        stall_out;
  logic        busy_out;
  logic        done_out;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int errors = 0;
  int checks = 0;

  muldiv_sequencer #(.W(32), .HI_RST(32'h0), .LO_RST(32'h0)) dut (
    .clk(clk), .reset(reset), .start_in(start_in), .op_in(op_in),
    .a_in(a_in), .b_in(b_in), .read_req_in(read_req_in),
    .stall_out(stall_out), .busy_out(busy_out), .done_out(done_out),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue an op in the current cycle (cycle 0) and run until done_out, bounded.
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    int busy_cnt;
    logic held;
    logic [31:0] ph;
    logic [31:0] pl;
    ph = hi_out;
    pl = lo_out;
    held = 1'b1;
    busy_cnt = 0;
    start_in = 1'b1; op_in = op; a_in = a; b_in = b;
    tick();
    start_in = 1'b0;
    lat = 1;
    #1;
    while (!done_out && lat < 100) begin
      if (busy_out) busy_cnt++;
      if (hi_out !== ph || lo_out !== pl) held = 1'b0;
      tick();
      #1;
      lat++;
    end
    chk({name, " latency"}, 64'(lat), 64'd34);
    chk({name, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    chk({name, " hold"}, 64'(held), 64'd1);
    chk({name, " busy_in_done"}, 64'(busy_out), 64'd0);
    chk({name, " hi"}, 64'(hi_out), 64'(ehi));
    chk({name, " lo"}, 64'(lo_out), 64'(elo));
    tick();
    chk({name, " done_pulse"}, 64'(done_out), 64'd0);
  endtask

  initial begin
    int c;
    logic ok;
    vecs[0]  = '{"multu_max",  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{"mult_m3x7",  3'b000, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{"div_m7d2",   3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_7d0",   3'b011, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
    vecs[4]  = '{"div_ovf",    3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{"div_7dm2",   3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6]  = '{"multu_5x6",  3'b001, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0000001E};
    vecs[7]  = '{"div_m5d0",   3'b010, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[8]  = '{"mult_min2",  3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{"divu_big",   3'b011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};
    vecs[10] = '{"mult_m1m1",  3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

    reset = 1'b1; start_in = 1'b0; op_in = 3'b110; a_in = '0; b_in = '0; read_req_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst busy", 64'(busy_out), 64'd0);
    chk("rst done", 64'(done_out), 64'd0);
    chk("rst stall", 64'(stall_out), 64'd0);
    chk("rst hi", 64'(hi_out), 64'd0);
    chk("rst lo", 64'(lo_out), 64'd0);

    // MTHI then MTLO, then an 11x no-op
    tick();
    start_in = 1'b1; op_in = 3'b100; a_in = 32'h1234;
    tick();
    chk("mthi hi", 64'(hi_out), 64'h1234);
    chk("mthi busy", 64'(busy_out), 64'd0);
    op_in = 3'b101; a_in = 32'h5678;
    #1;
    chk("mthi stall", 64'(stall_out), 64'd0);
    tick();
    chk("mtlo lo", 64'(lo_out), 64'h5678);
    chk("mtlo hi", 64'(hi_out), 64'h1234);
    chk("mtlo busy", 64'(busy_out), 64'd0);
    op_in = 3'b110; a_in = 32'hDEAD;
    tick();
    start_in = 1'b0;
    chk("nop busy", 64'(busy_out), 64'd0);
    chk("nop hi", 64'(hi_out), 64'h1234);
    chk("nop lo", 64'(lo_out), 64'h5678);

    for (int i = 0; i < 11; i++)
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Stall sequence: MULTU 5*6, read_req from cycle 2, extra start in cycle 5
    start_in = 1'b1; op_in = 3'b001; a_in = 32'd5; b_in = 32'd6;
    tick();
    start_in = 1'b0;
    ok = 1'b1;
    for (c = 1; c <= 33; c++) begin
      read_req_in = (c >= 2);
      start_in = (c == 5);
      if (c == 5) begin op_in = 3'b001; a_in = 32'd100; b_in = 32'd100; end
      #1;
      if (stall_out !== (c >= 2)) ok = 1'b0;
      tick();
    end
    start_in = 1'b0;
    #1;
    chk("stall window", 64'(ok), 64'd1);
    chk("stall done_cycle", 64'(stall_out), 64'd0);
    chk("stall done", 64'(done_out), 64'd1);
    chk("stall lo", 64'(lo_out), 64'd30);
    tick();
    read_req_in = 1'b0;
    tick();
    chk("stall not_accepted", 64'(busy_out), 64'd0);
    chk("stall lo_kept", 64'(lo_out), 64'd30);

    // Reset in cycle 10 of a MULT
    start_in = 1'b1; op_in = 3'b000; a_in = 32'hFFFFFFFD; b_in = 32'd7;
    tick();
    start_in = 1'b0;
    for (c = 1; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", 64'(busy_out), 64'd0);
    chk("abort hi", 64'(hi_out), 64'd0);
    chk("abort lo", 64'(lo_out), 64'd0);
    chk("abort done", 64'(done_out), 64'd0);
    ok = 1'b1;
    for (c = 0; c < 40; c++) begin
      if (done_out !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'h0) ok = 1'b0;
      tick();
    end
    chk("abort quiet", 64'(ok), 64'd1);
    do_op("post_abort_2x3", 3'b001, 32'd2, 32'd3, 32'd0, 32'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
